// File: rtl/twm_master.sv
// Two-wire (SCL/SDA) initiator: serializes one 8-bit-address / 16-bit-data read or write
// per host request, LSB first, and captures the slave's reply word on reads.
module twm_master #(
    parameter int unsigned SCL_HALF = 2,
    parameter int unsigned TA_MAX   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        cmd,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        SCL,
    inout  wire         SDA
);

    localparam int unsigned HW = (SCL_HALF > 1) ? $clog2(SCL_HALF) : 1;
    localparam int unsigned TW = (TA_MAX > 1) ? $clog2(TA_MAX + 1) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCL_HALF - 1);
    localparam logic [TW-1:0] TA_LAST   = TW'(TA_MAX - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StCmd, StAddr, StWdata, StStop, StTurn, StRdata, StRstop, StDone
    } state_e;

    state_e          state;
    logic [HW-1:0]   half_cnt;
    logic [3:0]      bit_cnt;
    logic [TW-1:0]   ta_cnt;
    logic            cmd_q;
    logic [23:0]     tx_q;
    logic [15:0]     shift_q;
    logic            sda_oe;
    logic            sda_out;
    logic            sda_in;
    logic            bit_end;

    // Reset forces the line high combinationally so an abort never glitches SDA low.
    assign SDA     = reset ? 1'b1 : (sda_oe ? sda_out : 1'bz);
    assign sda_in  = SDA;
    assign bit_end = SCL && (half_cnt == HALF_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            half_cnt <= '0;
            bit_cnt  <= '0;
            ta_cnt   <= '0;
            cmd_q    <= 1'b0;
            tx_q     <= '0;
            shift_q  <= '0;
            sda_oe   <= 1'b1;
            sda_out  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            SCL      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != StIdle && state != StDone) begin
                if (half_cnt == HALF_LAST) begin
                    half_cnt <= '0;
                    SCL      <= ~SCL;
                end else begin
                    half_cnt <= half_cnt + HW'(1);
                end
            end
            case (state)
                StIdle: if (req) begin
                    state    <= StStart;
                    busy     <= 1'b1;
                    cmd_q    <= cmd;
                    tx_q     <= {wdata, addr};
                    sda_oe   <= 1'b1;
                    sda_out  <= 1'b0;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    ta_cnt   <= '0;
                    SCL      <= 1'b0;
                end
                StStart: if (bit_end) begin
                    state   <= StCmd;
                    sda_out <= cmd_q;
                end
                StCmd: if (bit_end) begin
                    state   <= StAddr;
                    bit_cnt <= '0;
                    sda_out <= tx_q[0];
                end
                // tx_q[0] is always the bit on the wire; address flows straight into data.
                StAddr: if (bit_end) begin
                    tx_q    <= tx_q >> 1;
                    sda_out <= tx_q[1];
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        if (cmd_q) begin
                            state <= StWdata;
                        end else begin
                            state  <= StTurn;
                            sda_oe <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                StWdata: if (bit_end) begin
                    tx_q <= tx_q >> 1;
                    if (bit_cnt == 4'd15) begin
                        state   <= StStop;
                        bit_cnt <= '0;
                        sda_out <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sda_out <= tx_q[1];
                    end
                end
                StStop: if (bit_end) begin
                    state <= StDone;
                    done  <= 1'b1;
                    err   <= 1'b0;
                end
                StTurn: if (bit_end) begin
                    if (!sda_in) begin
                        state   <= StRdata;
                        bit_cnt <= '0;
                    end else if (ta_cnt == TA_LAST) begin
                        state   <= StDone;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        sda_oe  <= 1'b1;
                        sda_out <= 1'b1;
                    end else begin
                        ta_cnt <= ta_cnt + TW'(1);
                    end
                end
                StRdata: if (bit_end) begin
                    shift_q <= {sda_in, shift_q[15:1]};
                    if (bit_cnt == 4'd15) begin
                        state   <= StRstop;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                StRstop: if (bit_end) begin
                    state   <= StDone;
                    done    <= 1'b1;
                    sda_oe  <= 1'b1;
                    sda_out <= 1'b1;
                    if (sda_in) begin
                        rdata <= shift_q;
                        err   <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_twm_master.sv
// Bench for twm_master: directed vector table, randomized transactions against a wire-level
// reference model, and hand-written reset / back-to-back / busy-request sequences.
module tb_twm_master;

    localparam int H     = 2;
    localparam int TA    = 8;
    localparam int LIMIT = 2 * H * 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        SCL;
    wire         SDA;

    logic        sl_oe = 1'b0;
    logic        sl_bit = 1'b1;

    assign SDA = sl_oe ? sl_bit : 1'bz;
    pullup (SDA);

    twm_master #(.SCL_HALF(H), .TA_MAX(TA)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .cmd   (cmd),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .rdata (rdata),
        .SCL   (SCL),
        .SDA   (SDA)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic        mon_q[$];
    logic        exp_q[$];
    int          exp_periods;
    logic        exp_err;
    logic [15:0] model_rdata;
    int          rise_total = 0;
    int          rise_base = 0;
    int          done_pulses = 0;
    bit          is_rd = 1'b0;
    int          sl_mode = 0;
    int          sl_turn = 0;
    logic [15:0] sl_data = '0;

    // Slave: presents each bit on SCL rise so the master sees it stable at SCL fall.
    always @(posedge SCL or negedge SCL or posedge reset) begin
        if (reset) begin
            sl_oe = 1'b0;
        end else if (SCL) begin
            rise_total = rise_total + 1;
            if (is_rd && sl_mode != 0) begin
                if (rise_total - rise_base == 11 + sl_turn) begin
                    sl_oe  = 1'b1;
                    sl_bit = 1'b0;
                end else if (rise_total - rise_base >= 12 + sl_turn &&
                             rise_total - rise_base <= 27 + sl_turn) begin
                    sl_bit = sl_data[rise_total - rise_base - 12 - sl_turn];
                end else if (rise_total - rise_base == 28 + sl_turn) begin
                    if (sl_mode == 2) sl_bit = 1'b0;
                    else sl_oe = 1'b0;
                end
            end
        end else if (sl_oe && rise_total - rise_base >= 28 + sl_turn) begin
            sl_oe = 1'b0;
        end
    end

    always @(posedge SCL) begin
        #2;
        mon_q.push_back(SDA);
    end

    always @(posedge clk) if (done) done_pulses = done_pulses + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected wire bits (sampled at SCL rise), length in SCL periods, and result.
    task automatic model(input bit c, input logic [7:0] a, input logic [15:0] w,
                         input int mode, input int turn, input logic [15:0] ret);
        exp_q = {};
        exp_q.push_back(1'b0);
        exp_q.push_back(c);
        for (int i = 0; i < 8; i++) exp_q.push_back(a[i]);
        if (c) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
            exp_q.push_back(1'b1);
            exp_err = 1'b0;
        end else if (mode != 0 && turn < TA) begin
            for (int i = 0; i < turn; i++) exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
            for (int i = 0; i < 16; i++) exp_q.push_back(ret[i]);
            exp_q.push_back(mode == 2 ? 1'b0 : 1'b1);
            exp_err = (mode == 2);
            if (mode == 1) model_rdata = ret;
        end else begin
            for (int i = 0; i < TA; i++) exp_q.push_back(1'b1);
            exp_err = 1'b1;
        end
        exp_periods = exp_q.size();
    endtask

    task automatic cmp_stream(input string name, input int base);
        int got_n;
        int bad;
        got_n = mon_q.size() - base;
        bad = -1;
        checks++;
        if (got_n == exp_q.size()) begin
            for (int i = 0; i < got_n; i++) begin
                if (mon_q[base + i] !== exp_q[i]) begin
                    bad = i;
                    break;
                end
            end
        end
        if (got_n != exp_q.size() || bad >= 0) begin
            errors++;
            $display("FAIL %s: %0d bits seen, %0d expected, first differing bit %0d",
                     name, got_n, exp_q.size(), bad);
        end
    endtask

    task automatic finish_txn(input int mbase, input bit poke, input bit hold);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < LIMIT && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_accept", 32'(busy), 32'd1);
            if (!hold) begin
                if (poke && (n == 20 || n == 50 || n == 100)) begin
                    req = 1'b1;
                    {cmd, addr, wdata} = 25'($urandom);
                end else begin
                    req = 1'b0;
                end
            end
            if (done) got = 1'b1;
        end
        chk("done_latency", got ? n : -1, exp_periods * 2 * H + 1);
        chk("err", 32'(err), 32'(exp_err));
        chk("rdata", 32'(rdata), 32'(model_rdata));
        cmp_stream("bit_stream", mbase);
        @(negedge clk);
        chk("done_one_clk", 32'({busy, done}), 32'd0);
    endtask

    task automatic prep(input bit c, input logic [7:0] a, input logic [15:0] w,
                        input int mode, input int turn, input logic [15:0] ret,
                        output int mbase);
        is_rd   = !c;
        sl_mode = mode;
        sl_turn = turn;
        sl_data = ret;
        model(c, a, w, mode, turn, ret);
        rise_base = rise_total;
        mbase = mon_q.size();
    endtask

    task automatic run_txn(input bit c, input logic [7:0] a, input logic [15:0] w,
                           input int mode, input int turn, input logic [15:0] ret,
                           input bit poke, input bit hold);
        int mbase;
        prep(c, a, w, mode, turn, ret, mbase);
        @(negedge clk);
        cmd = c;
        addr = a;
        wdata = w;
        req = 1'b1;
        finish_txn(mbase, poke, hold);
    endtask

    typedef struct {
        bit          c;
        logic [7:0]  a;
        logic [15:0] w;
        int          mode;
        int          turn;
        logic [15:0] ret;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int mbase;
        int dbase;
        int n;
        vecs[0] = '{1'b1, 8'h3C, 16'hA5F0, 0, 0, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 8'h81, 16'h0000, 1, 2, 16'h1234, 1'b0, 16'h1234};
        vecs[2] = '{1'b0, 8'h81, 16'h0000, 0, 0, 16'h0000, 1'b1, 16'h1234};
        vecs[3] = '{1'b0, 8'h42, 16'h0000, 2, 0, 16'hBEEF, 1'b1, 16'h1234};
        vecs[4] = '{1'b0, 8'hFF, 16'h0000, 1, 7, 16'h8001, 1'b0, 16'h8001};
        vecs[5] = '{1'b0, 8'h00, 16'h0000, 1, 8, 16'h5555, 1'b1, 16'h8001};

        reset = 1'b1;
        req = 1'b0;
        cmd = 1'b0;
        addr = '0;
        wdata = '0;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_scl", 32'(SCL), 32'd0);
        chk("reset_sda", 32'(SDA), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].c, vecs[i].a, vecs[i].w, vecs[i].mode, vecs[i].turn, vecs[i].ret,
                    1'b0, 1'b0);
            chk("vec_err", 32'(err), 32'(vecs[i].exp_err));
            chk("vec_rdata", 32'(rdata), 32'(vecs[i].exp_rdata));
        end

        // Requests while busy must not disturb the latched transaction.
        dbase = done_pulses;
        run_txn(1'b1, 8'hC3, 16'h0FF0, 0, 0, 16'h0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("single_done_pulse", done_pulses - dbase, 1);

        // Reset in the middle of write-data bit 7.
        is_rd = 1'b0;
        rise_base = rise_total;
        @(negedge clk);
        {cmd, addr, wdata} = {1'b1, 8'h5A, 16'h1357};
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (rise_total - rise_base < 18 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wdata_bit7", rise_total - rise_base, 18);
        dbase = done_pulses;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_scl", 32'(SCL), 32'd0);
        chk("abort_sda", 32'(SDA), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", done_pulses - dbase, 0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        run_txn(1'b1, 8'h5A, 16'h1357, 0, 0, 16'h0, 1'b0, 1'b0);

        // Back-to-back: req held through done; second request taken right after IDLE.
        run_txn(1'b1, 8'h11, 16'hCAFE, 0, 0, 16'h0, 1'b0, 1'b1);
        prep(1'b1, 8'hEE, 16'h0123, 0, 0, 16'h0, mbase);
        {cmd, addr, wdata} = {1'b1, 8'hEE, 16'h0123};
        finish_txn(mbase, 1'b0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            int md;
            md = $urandom_range(0, 5);
            run_txn(1'($urandom), 8'($urandom), 16'($urandom),
                    (md == 5) ? 2 : ((md == 0) ? 0 : 1), $urandom_range(0, 9),
                    16'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
